// File: rtl/uart_pkg.sv
// Shared types and constants for the message-streaming UART transmitter.
// Optional build macro UART_MSG_TX_PARITY_EN adds the PARITY state.
package uart_pkg;

  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned WAIT_ACT_TIMEOUT     = 8;
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 104;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_ACT,
    S_START,
    S_DATA,
`ifdef UART_MSG_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_GAP
  } state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: one-cycle bit_tick_o every CLKS_PER_BIT cycles.
// Holding clr_i high parks the count at zero so the next period starts cleanly.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic bit_tick_o
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  assign bit_tick_o = (cnt_q == 16'(CLKS_PER_BIT - 1));

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (clr_i || bit_tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_msg_tx.sv
// Streams zero-terminated messages from a request/acknowledge byte source onto a UART line.
// Frame is 8N1 by default, 8E1 when UART_MSG_TX_PARITY_EN is defined.
module uart_msg_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned GAP_BITS     = 10
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_enable,
  output logic       o_next,
  input  logic       i_act,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_msg_done
);

  state_t      state_q;
  logic [7:0]  data_q;
  logic [2:0]  bit_cnt_q;
  logic [2:0]  wait_cnt_q;
  logic [15:0] gap_cnt_q;
  logic        run_q;
  logic        tx_q;
  logic        next_q;
  logic        busy_q;
  logic        msg_done_q;
  logic        bit_tick;

  // Baud timer runs only in bit-timed states, so every frame and gap starts at count zero.
  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_i      (i_clock),
    .rst_i      (i_reset),
    .clr_i      (~run_q),
    .bit_tick_o (bit_tick)
  );

  assign o_tx       = tx_q;
  assign o_next     = next_q;
  assign o_busy     = busy_q;
  assign o_msg_done = msg_done_q;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      data_q     <= '0;
      bit_cnt_q  <= '0;
      wait_cnt_q <= '0;
      gap_cnt_q  <= '0;
      run_q      <= 1'b0;
      tx_q       <= 1'b1;
      next_q     <= 1'b0;
      busy_q     <= 1'b0;
      msg_done_q <= 1'b0;
    end else begin
      next_q     <= 1'b0;
      msg_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_enable) begin
            state_q <= S_REQ;
            next_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_REQ: begin
          state_q    <= S_WAIT_ACT;
          wait_cnt_q <= '0;
        end
        S_WAIT_ACT: begin
          if (i_act) begin
            run_q <= 1'b1;
            if (i_data != 8'h00) begin
              data_q  <= i_data;
              tx_q    <= 1'b0;
              state_q <= S_START;
            end else begin
              msg_done_q <= 1'b1;
              gap_cnt_q  <= '0;
              state_q    <= S_GAP;
            end
          end else if (wait_cnt_q == 3'(WAIT_ACT_TIMEOUT - 1)) begin
            state_q <= S_REQ;
            next_q  <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 3'd1;
          end
        end
        S_START: begin
          if (bit_tick) begin
            tx_q      <= data_q[0];
            bit_cnt_q <= '0;
            state_q   <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_tick) begin
            if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_MSG_TX_PARITY_EN
              tx_q    <= ^data_q;
              state_q <= S_PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= S_STOP;
`endif
            end else begin
              tx_q      <= data_q[bit_cnt_q + 3'd1];
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end
`ifdef UART_MSG_TX_PARITY_EN
        S_PARITY: begin
          if (bit_tick) begin
            tx_q    <= 1'b1;
            state_q <= S_STOP;
          end
        end
`endif
        S_STOP, S_GAP: begin
          if (bit_tick && (state_q == S_GAP) && (gap_cnt_q != 16'(GAP_BITS - 1))) begin
            gap_cnt_q <= gap_cnt_q + 16'd1;
          end else if (bit_tick) begin
            // Enable is only honoured at frame/gap boundaries, never mid-frame.
            run_q <= 1'b0;
            if (i_enable) begin
              state_q <= S_REQ;
              next_q  <= 1'b1;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          run_q   <= 1'b0;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_msg_tx.sv
// Directed bench for uart_msg_tx with CLKS_PER_BIT=4, GAP_BITS=2; frames are hand-computed constants.
module tb_uart_msg_tx;

  localparam int CPB = 4;
  localparam int GAP = 2;
`ifdef UART_MSG_TX_PARITY_EN
  localparam int NBITS = 11;
  localparam logic [10:0] FR_48 = 11'h490;
  localparam logic [10:0] FR_69 = 11'h4D2;
  localparam logic [10:0] FR_55 = 11'h4AA;
  localparam logic [10:0] FR_A5 = 11'h54A;
  localparam logic [10:0] FR_07 = 11'h60E;
  localparam logic [10:0] FR_03 = 11'h406;
`else
  localparam int NBITS = 10;
  localparam logic [10:0] FR_48 = 11'h290;
  localparam logic [10:0] FR_69 = 11'h2D2;
  localparam logic [10:0] FR_55 = 11'h2AA;
  localparam logic [10:0] FR_A5 = 11'h34A;
`endif
  localparam int FCYC = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       act = 1'b0;
  logic [7:0] dat = 8'h00;
  logic       nxt, tx, busy, done;

  int n_vec = 0;
  int n_bad = 0;

  uart_msg_tx #(.CLKS_PER_BIT(CPB), .GAP_BITS(GAP)) dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_enable   (en),
    .o_next     (nxt),
    .i_act      (act),
    .i_data     (dat),
    .o_tx       (tx),
    .o_busy     (busy),
    .o_msg_done (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_next();
    int k = 0;
    while (nxt !== 1'b1 && k < 40) begin
      step();
      k++;
    end
    chk("next_seen", nxt, 1'b1);
  endtask

  // Reply one cycle after o_next, then check every cycle of the frame.
  task automatic send(input logic [7:0] d, input logic [10:0] exp, input int drop_at, input bit inject);
    wait_next();
    step();
    act = 1'b1;
    dat = d;
    step();
    act = 1'b0;
    dat = 8'h00;
    chk("busy_in_frame", busy, 1'b1);
    for (int c = 0; c < FCYC; c++) begin
      chk($sformatf("tx_%02h_c%0d", d, c), tx, exp[c / CPB]);
      if (c == drop_at) en = 1'b0;
      if (inject && c >= FCYC - CPB) begin
        act = 1'b1;
        dat = c[0] ? 8'h00 : 8'h5A;
      end else begin
        act = 1'b0;
      end
      step();
    end
    act = 1'b0;
    dat = 8'h00;
  endtask

  task automatic end_msg();
    wait_next();
    step();
    act = 1'b1;
    dat = 8'h00;
    step();
    act = 1'b0;
    chk("msg_done_pulse", done, 1'b1);
    chk("msg_done_busy", busy, 1'b1);
    for (int g = 0; g < GAP * CPB; g++) begin
      chk($sformatf("gap_tx_%0d", g), tx, 1'b1);
      chk($sformatf("gap_next_%0d", g), nxt, 1'b0);
      if (g > 0) chk($sformatf("gap_done_%0d", g), done, 1'b0);
      step();
    end
    chk("next_after_gap", nxt, 1'b1);
  endtask

  initial begin
    repeat (3) step();
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_next", nxt, 1'b0);
    chk("rst_done", done, 1'b0);
    rst = 1'b0;
    step();
    chk("idle_no_next", nxt, 1'b0);
    chk("idle_busy", busy, 1'b0);
    en = 1'b1;
    step();
    chk("first_next", nxt, 1'b1);

    // "Hi" then terminator; STOP of the second byte carries stray i_act pulses.
    send(8'h48, FR_48, -1, 1'b0);
    chk("next_b2b_0", nxt, 1'b1);
    send(8'h69, FR_69, -1, 1'b1);
    chk("next_b2b_1", nxt, 1'b1);
    chk("no_done_b2b", done, 1'b0);
    end_msg();

    // Source silent: re-request every 9 cycles, line idle.
    for (int k = 0; k < 27; k++) begin
      chk($sformatf("to_next_%0d", k), nxt, (k % 9) == 0);
      chk($sformatf("to_tx_%0d", k), tx, 1'b1);
      step();
    end

    // Enable dropped during DATA: frame completes, then idle.
    send(8'h55, FR_55, 14, 1'b1);
    chk("drop_busy", busy, 1'b0);
    chk("drop_next", nxt, 1'b0);
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("idle_next_%0d", k), nxt, 1'b0);
      chk($sformatf("idle_tx_%0d", k), tx, 1'b1);
      chk($sformatf("idle_done_%0d", k), done, 1'b0);
      step();
    end

    // Reset during data bit 3 of 0xA5, then full resend.
    en = 1'b1;
    wait_next();
    step();
    act = 1'b1;
    dat = 8'hA5;
    step();
    act = 1'b0;
    dat = 8'h00;
    for (int c = 0; c < 18; c++) begin
      chk($sformatf("pre_a5_c%0d", c), tx, FR_A5[c / CPB]);
      step();
    end
    rst = 1'b1;
    step();
    chk("mid_rst_tx", tx, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_next", nxt, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    rst = 1'b0;
    step();
    chk("rst_renext", nxt, 1'b1);
    send(8'hA5, FR_A5, -1, 1'b0);
    end_msg();

`ifdef UART_MSG_TX_PARITY_EN
    send(8'h07, FR_07, -1, 1'b0);
    send(8'h03, FR_03, -1, 1'b0);
    end_msg();
`endif

    en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_msg_tx.md
UART_MSG_TX -- requirements
Module: uart_msg_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, clocks per UART bit (12 MHz / 115200); legal range 2..65535.
REQ-002 SHALL have parameter GAP_BITS, default 10, idle bit-times inserted after each message end.
REQ-003 SHALL have port i_clock, input, 1, sole clock; all logic on posedge.
REQ-004 SHALL have port i_reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port i_enable, input, 1, level; streaming runs while high.
REQ-006 SHALL have port o_next, output, 1, one-cycle byte request pulse to the upstream byte source.
REQ-007 SHALL have port i_act, input, 1, upstream reply; i_data valid in the same cycle.
REQ-008 SHALL have port i_data, input, 8, byte from the source; 8'h00 marks end of message.
REQ-009 SHALL have port o_tx, output, 1, serial line, idle high.
REQ-010 SHALL have port o_busy, output, 1, high in any state other than IDLE.
REQ-011 SHALL have port o_msg_done, output, 1, one-cycle pulse on end-of-message.

Function
REQ-012 States: IDLE, REQ, WAIT_ACT, START, DATA, PARITY (macro only), STOP, GAP.
REQ-013 IDLE -> REQ when i_enable=1; o_next=1 for exactly the one cycle spent in REQ; REQ -> WAIT_ACT.
REQ-014 WAIT_ACT: i_act=1 with i_data!=0 -> latch byte, -> START. i_act=1 with i_data==0 -> pulse o_msg_done, -> GAP. i_act=0 -> stay.
REQ-015 WAIT_ACT: 8 cycles without i_act -> back to REQ (re-request). Counter resets on each entry.
REQ-016 START: o_tx=0 for CLKS_PER_BIT cycles; DATA: 8 bits LSB first, CLKS_PER_BIT cycles each; STOP: o_tx=1 for CLKS_PER_BIT cycles.
REQ-017 After STOP: -> REQ if i_enable=1, else IDLE; no idle gap between consecutive bytes of one message.
REQ-018 GAP: o_tx=1 for GAP_BITS*CLKS_PER_BIT cycles, then -> REQ if i_enable=1, else IDLE.
REQ-019 i_enable deassert mid-frame SHALL NOT truncate the frame; sampled only in IDLE, after STOP, after GAP.
REQ-020 Latency: first o_tx falling edge SHALL occur exactly 1 cycle after the i_act cycle.
REQ-021 Bit counter 3 bits, baud counter 16 bits; both wrap-free (cleared on each bit/state entry).
REQ-022 i_act outside WAIT_ACT SHALL be ignored.
REQ-023 o_tx SHALL be registered (glitch-free).

Reset
REQ-024 i_reset=1 SHALL force IDLE, o_tx=1, o_next=0, o_busy=0, o_msg_done=0, counters and latched byte 0, in the same edge, including mid-frame.
REQ-025 After reset release, the first o_next SHALL occur no earlier than the cycle after i_enable is sampled high in IDLE.

Configuration
REQ-026 Macro UART_MSG_TX_PARITY_EN defined: PARITY state between DATA and STOP sends even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles; frame 8E1, 11 bits.
REQ-027 Macro undefined: no PARITY state, no parity logic; frame 8N1, 10 bits.

Structure
REQ-028 Package uart_pkg SHALL hold the state enum typedef, DATA_BITS=8, WAIT_ACT_TIMEOUT=8, and the default CLKS_PER_BIT constant.
REQ-029 Sub-module uart_baud_gen SHALL produce a one-cycle bit_tick every CLKS_PER_BIT cycles, restartable by a clear input; uart_msg_tx instantiates it once.

Verification (CLKS_PER_BIT=4, GAP_BITS=2 in sim)
REQ-030 Source model replying i_act one cycle after o_next with "Hi",00 -> o_tx frames 0x48, 0x69 (LSB first, 40 cycles each); o_msg_done pulse; 8 cycles high; new o_next.
REQ-031 i_enable=1 then 0 during DATA of byte 0x55 -> full frame 0,1,0,1,0,1,0,1,0,1 completes; then IDLE, o_busy=0, no further o_next.
REQ-032 Source never asserts i_act -> o_next re-pulses every 9 cycles; o_tx stays 1.
REQ-033 i_reset pulse during bit 3 of 0xA5 -> next cycle o_tx=1, o_busy=0, state IDLE; re-enable resends from a new o_next.
REQ-034 UART_MSG_TX_PARITY_EN defined, bytes 0x07 and 0x03 -> parity bits 1 and 0; 44 cycles per frame.
REQ-035 i_act pulses injected during STOP -> ignored; no extra bytes, no o_msg_done.
